// File: rtl/quant_seq_ctrl_pkg.sv
// Shared types and constants for the block-quantization sequencer.
// scale = amax * 2^-SCALE_SHIFT, floored at the smallest normal FP32 value.
package quant_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SCALE, DRAIN} qs_state_t;

  localparam int unsigned FP32_EXP_BIAS = 127;
  localparam int unsigned SCALE_SHIFT   = 7;
  localparam logic [31:0] FP32_MIN_NORM = 32'h0080_0000;

  // amax_mag is |amax| (sign already dropped); exponents below 8 would underflow.
  function automatic logic [31:0] calc_scale(input logic [30:0] amax_mag);
    if (amax_mag[30:23] >= 8'(SCALE_SHIFT + 1))
      return {1'b0, amax_mag[30:23] - 8'(SCALE_SHIFT), amax_mag[22:0]};
    else
      return FP32_MIN_NORM;
  endfunction

endpackage

// File: rtl/quant_seq_ctrl_quantization.sv
// FP32 -> INT8 quantization datapath: q = sat8(round_half_away(x / 2^(e_s - bias))).
// The step is the power of two given by the scale exponent; zero/denormal inputs give 0.
module quantization (
  input  logic [31:0] x_i,
  input  logic [7:0]  scale_exp_i,
  output logic [7:0]  q_o
);

  logic [23:0]       mant;
  logic [23:0]       shifted;
  logic [23:0]       rnd;
  logic signed [9:0] sh;
  logic [4:0]        rs;

  // Keep one fraction bit below the integer part so rounding is a +1 then >>1.
  always_comb begin
    mant    = {1'b1, x_i[22:0]};
    sh      = $signed({2'b00, x_i[30:23]}) - $signed({2'b00, scale_exp_i});
    rs      = 5'(10'sd22 - sh);
    shifted = mant >> rs;
    rnd     = (shifted + 24'd1) >> 1;
    q_o     = '0;
    if (x_i[30:23] == 8'h00) begin
      q_o = '0;
    end else if (sh > 10'sd7) begin
      q_o = x_i[31] ? 8'h80 : 8'h7F;
    end else if (sh >= -10'sd1) begin
      if (x_i[31])
        q_o = (rnd >= 24'd128) ? 8'h80 : (~rnd[7:0] + 8'd1);
      else
        q_o = (rnd >= 24'd128) ? 8'h7F : rnd[7:0];
    end
  end

endmodule

// File: rtl/quant_seq_ctrl.sv
// Block-quantization sequencer: buffers an FP32 block, tracks amax, derives the
// scale, then streams INT8 results through one quantization instance.
module quant_seq_ctrl
  import quant_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [31:0] scale_out,
  output logic        busy,
  output logic        sat_err
);

  qs_state_t         state_q, state_d;
  logic [31:0]       buf_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [30:0]       amax_q, amax_d;
  logic [31:0]       scale_q, scale_d;
  logic              zero_blk_q, zero_blk_d;
  logic              sat_q, sat_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [7:0]        out_data_q, out_data_d;

  logic              in_hs;
  logic              word_bad;
  logic [31:0]       wr_word;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic              load_en;
  logic              rd_last;
  logic [7:0]        q_res;

  assign in_ready = (state_q == IDLE) || (state_q == LOAD);
  assign in_hs    = in_valid && in_ready;
  assign word_bad = (in_data[30:23] == 8'hFF);
  assign wr_word  = word_bad ? '0 : in_data;
  // out_last_q marks that the final word is already in the output register.
  assign load_en  = (state_q == DRAIN) && (!out_valid_q || out_ready) && !out_last_q;
  // wr_ptr wraps to 0 after a full block, so wr_ptr-1 still names the last slot.
  assign rd_last  = (rd_ptr_q == ADDR_W'(wr_ptr_q - 1'b1));

  quantization u_quant (
    .x_i         (buf_q[rd_ptr_q]),
    .scale_exp_i (scale_q[30:23]),
    .q_o         (q_res)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    amax_d      = amax_q;
    scale_d     = scale_q;
    zero_blk_d  = zero_blk_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    wr_en       = 1'b0;
    wr_idx      = wr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          wr_en    = 1'b1;
          wr_idx   = '0;
          wr_ptr_d = ADDR_W'(1);
          sat_d    = word_bad;
          amax_d   = wr_word[30:0];
          state_d  = in_last ? SCALE : LOAD;
        end
      end
      LOAD: begin
        if (in_hs) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (word_bad) sat_d = 1'b1;
          if (wr_word[30:0] > amax_q) amax_d = wr_word[30:0];
          if (in_last || (wr_ptr_q == ADDR_W'(DEPTH - 1))) state_d = SCALE;
        end
      end
      SCALE: begin
        scale_d    = calc_scale(amax_q);
        zero_blk_d = (amax_q == '0);
        rd_ptr_d   = '0;
        state_d    = DRAIN;
      end
      DRAIN: begin
        if (load_en) begin
          out_valid_d = 1'b1;
          out_data_d  = zero_blk_q ? '0 : q_res;
          out_last_d  = rd_last;
          rd_ptr_d    = rd_ptr_q + 1'b1;
        end else if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          wr_ptr_d    = '0;
          amax_d      = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      amax_q      <= '0;
      scale_q     <= '0;
      zero_blk_q  <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      amax_q      <= amax_d;
      scale_q     <= scale_d;
      zero_blk_q  <= zero_blk_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx] <= wr_word;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign scale_out = scale_q;
  assign busy      = (state_q != IDLE);
  assign sat_err   = sat_q;

endmodule

// File: tb/tb_quant_seq_ctrl.sv
// Directed, table-driven bench for quant_seq_ctrl: blocks of FP32 words with
// hand-computed INT8 results, scales and error flags.
module tb_quant_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [31:0] scale_out;
  logic        busy;
  logic        sat_err;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  typedef struct packed {
    logic [31:0] din;
    logic        lst;
    logic [7:0]  q;
  } vec_t;

  typedef struct packed {
    int unsigned first;
    int unsigned len;
    logic [31:0] scale;
    logic        sat;
    int unsigned mode;
  } blk_t;

  vec_t vecs [26];
  blk_t blks [6];

  quant_seq_ctrl #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .scale_out (scale_out),
    .busy      (busy),
    .sat_err   (sat_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send_block(input int unsigned first, input int unsigned len);
    for (int unsigned i = 0; i < len; i++) begin
      int unsigned w = 0;
      in_valid = 1'b1;
      in_data  = vecs[first + i].din;
      in_last  = vecs[first + i].lst;
      while (!in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0 repeating
  task automatic drain_block(input int unsigned first, input int unsigned len, input int unsigned mode);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    logic        have_prev = 1'b0;
    logic [7:0]  prev_d = '0;
    logic        prev_l = 1'b0;
    while (idx < len && cyc < 300) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (have_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_d));
        chk("stall_last", 32'(out_last), 32'(prev_l));
      end
      have_prev = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk($sformatf("data[%0d]", first + idx), 32'(out_data), 32'(vecs[first + idx].q));
          chk($sformatf("last[%0d]", first + idx), 32'(out_last), 32'(idx == len - 1));
          idx++;
        end else begin
          have_prev = 1'b1;
          prev_d    = out_data;
          prev_l    = out_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (idx < len) chk("drain_count", idx, len);
    out_ready = 1'b0;
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_block(input blk_t b);
    send_block(b.first, b.len);
    chk("in_ready_after_last", 32'(in_ready), 32'd0);
    chk("busy_after_last", 32'(busy), 32'd1);
    chk("lat_scale_cycle", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_drain_cycle", 32'(out_valid), 32'd0);
    chk("scale_out", scale_out, b.scale);
    @(posedge clk); #1;
    chk("lat_first_valid", 32'(out_valid), 32'd1);
    drain_block(b.first, b.len, b.mode);
    chk("scale_held", scale_out, b.scale);
    chk("sat_err", 32'(sat_err), 32'(b.sat));
  endtask

  initial begin
    // block A: {1.0, -2.0, 0.5, 4.0}, step 2^-5
    vecs[0]  = '{32'h3F80_0000, 1'b0, 8'h20};
    vecs[1]  = '{32'hC000_0000, 1'b0, 8'hC0};
    vecs[2]  = '{32'h3F00_0000, 1'b0, 8'h10};
    vecs[3]  = '{32'h4080_0000, 1'b1, 8'h7F};
    // block B: 16 words, no in_last, amax 8.0, step 2^-4
    vecs[4]  = '{32'h3E80_0000, 1'b0, 8'h04};
    vecs[5]  = '{32'hBE80_0000, 1'b0, 8'hFC};
    vecs[6]  = '{32'h3F00_0000, 1'b0, 8'h08};
    vecs[7]  = '{32'hBF00_0000, 1'b0, 8'hF8};
    vecs[8]  = '{32'h3F80_0000, 1'b0, 8'h10};
    vecs[9]  = '{32'hBF80_0000, 1'b0, 8'hF0};
    vecs[10] = '{32'h4000_0000, 1'b0, 8'h20};
    vecs[11] = '{32'hC000_0000, 1'b0, 8'hE0};
    vecs[12] = '{32'h4080_0000, 1'b0, 8'h40};
    vecs[13] = '{32'hC080_0000, 1'b0, 8'hC0};
    vecs[14] = '{32'h4100_0000, 1'b0, 8'h7F};
    vecs[15] = '{32'hC100_0000, 1'b0, 8'h80};
    vecs[16] = '{32'h3F40_0000, 1'b0, 8'h0C};
    vecs[17] = '{32'h3FC0_0000, 1'b0, 8'h18};
    vecs[18] = '{32'h3D00_0000, 1'b0, 8'h01};
    vecs[19] = '{32'hBD00_0000, 1'b0, 8'hFF};
    // block C: {0.0, -0.0}
    vecs[20] = '{32'h0000_0000, 1'b0, 8'h00};
    vecs[21] = '{32'h8000_0000, 1'b1, 8'h00};
    // block D: {2.0, NaN, 8.0}; NaN slot stored as zero
    vecs[22] = '{32'h4000_0000, 1'b0, 8'h20};
    vecs[23] = '{32'h7FC0_0000, 1'b0, 8'h00};
    vecs[24] = '{32'h4100_0000, 1'b1, 8'h7F};
    // block E: single tiny word 2^-125, scale floors at min normal
    vecs[25] = '{32'h0100_0000, 1'b1, 8'h02};

    blks[0] = '{0,  4,  32'h3D00_0000, 1'b0, 0};
    blks[1] = '{0,  4,  32'h3D00_0000, 1'b0, 1};
    blks[2] = '{4,  16, 32'h3D80_0000, 1'b0, 0};
    blks[3] = '{20, 2,  32'h0080_0000, 1'b0, 0};
    blks[4] = '{22, 3,  32'h3D80_0000, 1'b1, 0};
    blks[5] = '{25, 1,  32'h0080_0000, 1'b0, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_scale", scale_out, 32'd0);
    chk("rst_sat", 32'(sat_err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int unsigned b = 0; b < 6; b++) run_block(blks[b]);

    // reset while results are being streamed
    send_block(0, 4);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    run_block(blks[0]);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
